// File: rtl/pca_register_file_pkg.sv
// Shared PCA9685 register map constants, MODE1 bit positions, reset defaults
// and small address-classification helpers for the register file.
package pca_register_file_pkg;

  localparam logic [7:0] PCA_MODE1         = 8'h00;
  localparam logic [7:0] PCA_MODE2         = 8'h01;
  localparam logic [7:0] PCA_SUBADR1       = 8'h02;
  localparam logic [7:0] PCA_SUBADR2       = 8'h03;
  localparam logic [7:0] PCA_SUBADR3       = 8'h04;
  localparam logic [7:0] PCA_ALLCALLADR    = 8'h05;
  localparam logic [7:0] PCA_LED0_ON_L     = 8'h06;
  localparam logic [7:0] PCA_LED15_OFF_H   = 8'h45;
  localparam logic [7:0] PCA_ALL_LED_ON_L  = 8'hFA;
  localparam logic [7:0] PCA_ALL_LED_OFF_H = 8'hFD;
  localparam logic [7:0] PCA_PRE_SCALE     = 8'hFE;
  localparam logic [7:0] PCA_TESTMODE      = 8'hFF;

  localparam int MODE1_RESTART = 7;
  localparam int MODE1_SLEEP   = 4;

  localparam logic [7:0] RST_MODE1      = 8'h11;
  localparam logic [7:0] RST_MODE2      = 8'h04;
  localparam logic [7:0] RST_SUBADR1    = 8'hE2;
  localparam logic [7:0] RST_SUBADR2    = 8'hE4;
  localparam logic [7:0] RST_SUBADR3    = 8'hE8;
  localparam logic [7:0] RST_ALLCALLADR = 8'hE0;
  localparam logic [7:0] RST_PRE_SCALE  = 8'h1E;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_FANOUT = 1'b1
  } fanout_state_e;

  function automatic logic [7:0] reset_value(input logic [7:0] id);
    logic [7:0] v;
    v = 8'h00;
    case (id)
      PCA_MODE1:      v = RST_MODE1;
      PCA_MODE2:      v = RST_MODE2;
      PCA_SUBADR1:    v = RST_SUBADR1;
      PCA_SUBADR2:    v = RST_SUBADR2;
      PCA_SUBADR3:    v = RST_SUBADR3;
      PCA_ALLCALLADR: v = RST_ALLCALLADR;
      PCA_PRE_SCALE:  v = RST_PRE_SCALE;
      default:        v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic is_all_led(input logic [7:0] id);
    return (id >= PCA_ALL_LED_ON_L) && (id <= PCA_ALL_LED_OFF_H);
  endfunction

  // Ordinary byte stores: everything except MODE1, PRE_SCALE, ALL_LED, reserved
  function automatic logic is_plain(input logic [7:0] id);
    return ((id >= PCA_MODE2) && (id <= PCA_LED15_OFF_H)) || (id == PCA_TESTMODE);
  endfunction

  function automatic logic is_readable(input logic [7:0] id);
    return (id <= PCA_LED15_OFF_H) || (id >= PCA_PRE_SCALE);
  endfunction

  function automatic logic [7:0] mode1_next(input logic [7:0] cur,
                                            input logic [7:0] wr,
                                            input logic       running);
    logic restart;
    restart = cur[MODE1_RESTART];
    if (wr[MODE1_RESTART]) restart = 1'b0;
    // Going to sleep with the oscillator running leaves a restart pending
    if (running && !cur[MODE1_SLEEP] && wr[MODE1_SLEEP]) restart = 1'b1;
    return {restart, wr[6:0]};
  endfunction

endpackage

// File: rtl/pca_osc_wake.sv
// Oscillator wake timer: down-counter loaded while asleep, pwm_run_o asserts
// once it has run down OSC_WAKE_CYCLES cycles after SLEEP clears.
module pca_osc_wake
  import pca_register_file_pkg::*;
#(
  parameter int unsigned OSC_WAKE_CYCLES = 12500
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sleep_i,
  output logic pwm_run_o
);

  localparam int unsigned CNT_W = (OSC_WAKE_CYCLES > 2) ? $clog2(OSC_WAKE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OSC_WAKE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (sleep_i) begin
      cnt_d = CNT_LOAD;
      run_d = 1'b0;
    end else if (!run_q) begin
      if (cnt_q == '0) run_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CNT_LOAD;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign pwm_run_o = run_q;

endmodule

// File: rtl/pca_register_file.sv
// PCA9685-compatible 256-byte register map behind the I2C target write port.
//   state     | meaning
//   ST_IDLE   | applying single writes (direct or from the pending slot)
//   ST_FANOUT | copying a latched ALL_LED byte into one LED column, 16 cycles
module pca_register_file
  import pca_register_file_pkg::*;
#(
  parameter int unsigned OSC_WAKE_CYCLES = 12500
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    write_register_id_i,
  input  logic [7:0]    write_register_value_i,
  input  logic          write_enable_i,
  output logic [2047:0] register_blob_o,
  output logic          busy_o,
  output logic          pwm_run_o,
  output logic [7:0]    prescale_o
);

  logic [7:0]    regs_q [256];
  logic [7:0]    regs_d [256];
  fanout_state_e state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [1:0]    k_q, k_d;
  logic [7:0]    fan_val_q, fan_val_d;

  logic          en_prev_q;
  logic          req_v_q, req_ok_q;
  logic [7:0]    req_id_q, req_val_q;
  logic          pend_v_q, pend_v_d, pend_ok_q, pend_ok_d;
  logic [7:0]    pend_id_q, pend_id_d, pend_val_q, pend_val_d;

  logic          accept, sleep, busy, chain, pend_take, pend_free, req_to_pend;
  logic          op_v, op_ok, pwm_run;
  logic [7:0]    op_id, op_val, fan_addr;

  assign accept   = write_enable_i & ~en_prev_q;
  assign sleep    = regs_q[PCA_MODE1][MODE1_SLEEP];
  assign busy     = (state_q == ST_FANOUT);
  assign fan_addr = PCA_LED0_ON_L + {2'b00, idx_q, 2'b00} + {6'b000000, k_q};

  // A pending ALL_LED write takes over on the last fan-out cycle so there is no idle gap
  assign chain       = busy && (idx_q == 4'hF) && pend_v_q && is_all_led(pend_id_q);
  assign pend_take   = (pend_v_q && !busy) || chain;
  assign pend_free   = !pend_v_q || pend_take;
  assign req_to_pend = req_v_q && pend_free && (busy || pend_v_q);

  assign op_v   = !busy && (pend_v_q || req_v_q);
  assign op_id  = pend_v_q ? pend_id_q  : req_id_q;
  assign op_val = pend_v_q ? pend_val_q : req_val_q;
  assign op_ok  = pend_v_q ? pend_ok_q  : req_ok_q;

  // PRE_SCALE lock is sampled from SLEEP when the edge is accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_prev_q <= 1'b0;
      req_v_q   <= 1'b0;
      req_id_q  <= 8'h00;
      req_val_q <= 8'h00;
      req_ok_q  <= 1'b0;
    end else begin
      en_prev_q <= write_enable_i;
      req_v_q   <= accept;
      if (accept) begin
        req_id_q  <= write_register_id_i;
        req_val_q <= write_register_value_i;
        req_ok_q  <= sleep;
      end
    end
  end

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_id_d  = pend_id_q;
    pend_val_d = pend_val_q;
    pend_ok_d  = pend_ok_q;
    if (pend_take) pend_v_d = 1'b0;
    if (req_to_pend) begin
      pend_v_d   = 1'b1;
      pend_id_d  = req_id_q;
      pend_val_d = req_val_q;
      pend_ok_d  = req_ok_q;
    end
  end

  always_comb begin
    regs_d    = regs_q;
    state_d   = state_q;
    idx_d     = idx_q;
    k_d       = k_q;
    fan_val_d = fan_val_q;
    unique case (state_q)
      ST_IDLE: begin
        if (op_v) begin
          if (is_all_led(op_id)) begin
            state_d   = ST_FANOUT;
            idx_d     = 4'h0;
            k_d       = 2'(op_id - PCA_ALL_LED_ON_L);
            fan_val_d = op_val;
          end else if (op_id == PCA_MODE1) begin
            regs_d[PCA_MODE1] = mode1_next(regs_q[PCA_MODE1], op_val, pwm_run);
          end else if (op_id == PCA_PRE_SCALE) begin
            if (op_ok) regs_d[PCA_PRE_SCALE] = op_val;
          end else if (is_plain(op_id)) begin
            regs_d[op_id] = op_val;
          end
        end
      end
      ST_FANOUT: begin
        regs_d[fan_addr] = fan_val_q;
        idx_d            = idx_q + 4'h1;
        if (idx_q == 4'hF) begin
          if (chain) begin
            idx_d     = 4'h0;
            k_d       = 2'(pend_id_q - PCA_ALL_LED_ON_L);
            fan_val_d = pend_val_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= reset_value(8'(i));
      state_q    <= ST_IDLE;
      idx_q      <= 4'h0;
      k_q        <= 2'b00;
      fan_val_q  <= 8'h00;
      pend_v_q   <= 1'b0;
      pend_id_q  <= 8'h00;
      pend_val_q <= 8'h00;
      pend_ok_q  <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      fan_val_q  <= fan_val_d;
      pend_v_q   <= pend_v_d;
      pend_id_q  <= pend_id_d;
      pend_val_q <= pend_val_d;
      pend_ok_q  <= pend_ok_d;
    end
  end

  pca_osc_wake #(
    .OSC_WAKE_CYCLES(OSC_WAKE_CYCLES)
  ) u_osc_wake (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sleep_i  (sleep),
    .pwm_run_o(pwm_run)
  );

  // Byte i sits MSB-first starting at bit i*8; reserved and ALL_LED read as zero
  always_comb begin
    register_blob_o = '0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (is_readable(8'(i))) register_blob_o[i*8+j] = regs_q[i][7-j];
      end
    end
  end

  assign busy_o     = busy;
  assign pwm_run_o  = pwm_run;
  assign prescale_o = regs_q[PCA_PRE_SCALE];

endmodule
